// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO feeding IF/ID; FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Latency: ack data visible the cycle after imem_ack (in the ack cycle itself with bypass on an empty queue).
// Backpressure: fetch_stall holds the head; new fetches stop while queue plus in-flight slot is full.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   fetch_stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  output logic [31:0]            instr_out,
  output logic [31:0]            pc_out,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, addr_q, pc_hold_q, issue_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_after;
  logic          head_vld, ack_keep, push, pop, issue;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic          bypass_hit;
`endif

  // A redirect kills both the pop and the push of the cycle it is seen in.
  always_comb begin
    head_vld = count_q != '0;
    ack_keep = (state_q == WAIT) && imem_ack && !redirect;
    pop      = head_vld && !fetch_stall && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_hit = ack_keep && !head_vld;
    push       = ack_keep && !(bypass_hit && !fetch_stall);
`else
    push       = ack_keep;
`endif
    count_after = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!redirect && count_q < FULL) state_d = WAIT;
      WAIT: begin
        if (redirect)      state_d = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_d = (count_after < FULL) ? WAIT : IDLE;
      end
      // A stale request completing together with a fresh redirect leaves nothing in flight.
      DROP: if (imem_ack) state_d = redirect ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = state_q != IDLE;
    imem_addr = addr_q;
  end

  // Back-to-back reissue targets the word after the one just acked; IDLE/DROP issue fetch_pc as is.
  always_comb begin
    issue    = (state_d == WAIT) && ((state_q != WAIT) || imem_ack);
    issue_pc = (state_q == WAIT) ? fetch_pc_q + 32'd4 : fetch_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pc_hold_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_hold_q <= pc_out;
      if (issue) addr_q <= issue_pc;
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (ack_keep) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)     wr_ptr_q   <= wr_ptr_q + AW'(1);
        if (pop)      rd_ptr_q   <= rd_ptr_q + AW'(1);
        count_q <= count_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr_q]    <= addr_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    instr_valid = head_vld;
    instr_out   = head_vld ? instr_mem[rd_ptr_q] : NOP_INSTR;
    pc_out      = head_vld ? pc_mem[rd_ptr_q] : pc_hold_q;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass_hit) begin
      instr_valid = 1'b1;
      instr_out   = imem_rdata;
      pc_out      = addr_q;
    end
`endif
    q_count = count_q;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected fetch addresses and
// {pc,instr} pops; a memory responder and an output monitor check them independently.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  q_count;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;

  ent_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 0;
  int          budget = 0;
  logic [31:0] base = 32'h0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  int          first_ack = -1;

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_stall(fetch_stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_out(pc_out), .q_count(q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  // Memory: acks after `lat` wait cycles while budget remains; rdata = base + word index.
  initial begin
    int          cnt;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] exp_a;
    cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        if (!prev_req || prev_ack) cnt = 0;
        else cnt++;
      end
      if (imem_req && cnt >= lat && budget > 0) begin
        imem_ack   = 1'b1;
        imem_rdata = base + (imem_addr >> 2);
        budget--;
        if (first_ack < 0) first_ack = cyc;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_addr: got %h, expected no request", imem_addr);
        end else begin
          exp_a = addr_q.pop_front();
          chk("ack_addr", imem_addr, exp_a);
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
    end
  end

  // Monitor: every accepted head entry must match the scoreboard front.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset && instr_valid && !fetch_stall && !redirect) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_unexpected: got pc %h instr %h, expected no output", pc_out, instr_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", pc_out, e.pc);
          chk("pop_instr", instr_out, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic hold_reset(int l, logic [31:0] b, logic st);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    fetch_stall = st; lat = l; base = b; budget = 0;
    repeat (2) step();
  endtask

  task automatic release_reset(int bud);
    pops = 0; first_pop = -1; last_pop = -1; first_ack = -1;
    budget = bud;
    reset = 1'b0;
  endtask

  task automatic exp_push(logic [31:0] pc, logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  task automatic end_phase(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d outputs missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
    chk({name, "_addrs_left"}, 32'(addr_q.size()), 32'd0);
    addr_q.delete();
  endtask

  task automatic wait_req_addr(logic [31:0] a, string name);
    int n;
    n = 0;
    while (!(imem_req && imem_addr == a) && n < 60) begin
      step();
      n++;
    end
    if (!(imem_req && imem_addr == a)) timeout(name);
  endtask

  initial begin
    int n;
    reset = 1'b1; fetch_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Phase 1: zero-wait memory, no stall, streaming
    hold_reset(0, 32'h1000_0000, 1'b0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_count", 32'(q_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      exp_push(32'(4 * i), 32'h1000_0000 + 32'(i));
      addr_q.push_back(32'(4 * i));
    end
    release_reset(6);
    end_phase("p1");
    chk("p1_pops", 32'(pops), 32'd6);
    chk("p1_spacing", 32'(last_pop - first_pop), 32'd5);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("p1_first_valid", 32'(first_pop - first_ack), 32'd0);
`else
    chk("p1_first_valid", 32'(first_pop - first_ack), 32'd1);
`endif

    // Phase 2: stall until full, then drain and refetch from 16
    hold_reset(0, 32'h0000_00A0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_push(32'(4 * i), 32'hA0 + 32'(i));
      addr_q.push_back(32'(4 * i));
    end
    release_reset(8);
    repeat (12) step();
    chk("p2_count", 32'(q_count), 32'd4);
    chk("p2_req",   32'(imem_req), 32'd0);
    chk("p2_valid", 32'(instr_valid), 32'd1);
    chk("p2_pc",    pc_out, 32'h0);
    chk("p2_instr", instr_out, 32'hA0);
    chk("p2_pops",  32'(pops), 32'd0);
    fetch_stall = 1'b0;
    end_phase("p2");

    // Phase 3: slow memory, redirect while waiting on addr 8
    hold_reset(3, 32'h3000_0000, 1'b0);
    exp_push(32'h0,   32'h3000_0000);
    exp_push(32'h4,   32'h3000_0001);
    exp_push(32'h100, 32'h3000_0040);
    exp_push(32'h104, 32'h3000_0041);
    addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    release_reset(5);
    wait_req_addr(32'h8, "p3_wait_addr8");
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("p3_req",   32'(imem_req), 32'd1);
    chk("p3_addr",  imem_addr, 32'h8);
    chk("p3_count", 32'(q_count), 32'd0);
    chk("p3_valid", 32'(instr_valid), 32'd0);
    end_phase("p3");

    // Phase 4: redirect coinciding with ack and pop, unaligned target
    hold_reset(0, 32'h4000_0000, 1'b0);
    exp_push(32'h0, 32'h4000_0000);
    exp_push(32'h4, 32'h4000_0001);
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_push(32'h8, 32'h4000_0002);
`endif
    exp_push(32'h200, 32'h4000_0080);
    exp_push(32'h204, 32'h4000_0081);
    addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204};
    release_reset(6);
    wait_req_addr(32'hC, "p4_wait_addrC");
    chk("p4_ack", 32'(imem_ack), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("p4_req",     32'(imem_req), 32'd0);
    chk("p4_count",   32'(q_count), 32'd0);
    chk("p4_valid",   32'(instr_valid), 32'd0);
    chk("p4_pc_hold", pc_out, 32'h8);
    step();
    chk("p4_req2", 32'(imem_req), 32'd1);
    chk("p4_addr", imem_addr, 32'h200);
    end_phase("p4");

    // Phase 5: reset while waiting with two entries queued
    hold_reset(0, 32'h5000_0000, 1'b1);
    addr_q = '{32'h0, 32'h4, 32'h8};
    release_reset(3);
    n = 0;
    while (!(imem_req && q_count == 3'd2) && n < 60) begin
      step();
      n++;
    end
    if (!(imem_req && q_count == 3'd2)) timeout("p5_wait_count2");
    reset = 1'b1;
    step();
    chk("p5_req",   32'(imem_req), 32'd0);
    chk("p5_count", 32'(q_count), 32'd0);
    chk("p5_valid", 32'(instr_valid), 32'd0);
    chk("p5_instr", instr_out, 32'h0000_0013);
    chk("p5_pc",    pc_out, 32'h0);
    reset = 1'b0;
    end_phase("p5");

    // Phase 6: first word into an empty queue
    hold_reset(2, 32'h0050_0093, 1'b0);
    exp_push(32'h0, 32'h0050_0093);
    addr_q.push_back(32'h0);
    release_reset(1);
    n = 0;
    while (!imem_ack && n < 60) begin
      step();
      n++;
    end
    if (!imem_ack) timeout("p6_wait_ack");
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("p6_valid", 32'(instr_valid), 32'd1);
    chk("p6_instr", instr_out, 32'h0050_0093);
    chk("p6_pc",    pc_out, 32'h0);
    step();
    chk("p6_count", 32'(q_count), 32'd0);
`else
    chk("p6_valid", 32'(instr_valid), 32'd0);
    chk("p6_instr", instr_out, 32'h0000_0013);
    step();
    chk("p6_count",  32'(q_count), 32'd1);
    chk("p6_valid2", 32'(instr_valid), 32'd1);
`endif
    end_phase("p6");

    // Phase 7: redirect near the top of memory, fetch_pc wraps to 0
    hold_reset(0, 32'h0, 1'b0);
    exp_push(32'hFFFF_FFF8, 32'h3FFF_FFFE);
    exp_push(32'hFFFF_FFFC, 32'h3FFF_FFFF);
    exp_push(32'h0, 32'h0);
    exp_push(32'h4, 32'h1);
    addr_q = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    release_reset(0);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; budget = 5;
    step();
    redirect = 1'b0;
    chk("p7_req",  32'(imem_req), 32'd1);
    chk("p7_addr", imem_addr, 32'h0);
    end_phase("p7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
